// File: rtl/sr_cond_pkg.sv
// Shared types and default constants for the SR pulse conditioner.
// Debounce FSM state encoding plus default stability count and counter width.
package sr_cond_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CHK_HI = 2'd1,
        HELD   = 2'd2,
        CHK_LO = 2'd3
    } db_state_e;

    localparam int DEF_DB_CYCLES = 8;
    localparam int DEF_CNT_W     = 4;

endpackage

// File: rtl/debounce_channel.sv
// One button channel: 2-flop synchronizer, 4-state debounce FSM with a
// stability counter, and a registered one-cycle rise pulse on qualified press.
module debounce_channel
    import sr_cond_pkg::*;
#(
    parameter int DB_CYCLES = DEF_DB_CYCLES,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn,
    output logic o_rise
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]       r_sync;
    db_state_e        r_state;
    db_state_e        w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_rise;
    logic             w_rise_nxt;
    logic             w_sync;

    assign w_sync = r_sync[1];
    assign o_rise = r_rise;

    // Next-state, counter and rise decode; counter only advances below CNT_LAST.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_rise_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_sync) begin
                    w_state_nxt = CHK_HI;
                    w_cnt_nxt   = CNT_ZERO;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            CHK_HI: begin
                if (!w_sync) begin
                    w_state_nxt = IDLE;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = HELD;
                    w_rise_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            HELD: begin
                if (!w_sync) begin
                    w_state_nxt = CHK_LO;
                    w_cnt_nxt   = CNT_ZERO;
                end else begin
                    w_state_nxt = HELD;
                end
            end
            CHK_LO: begin
                if (w_sync) begin
                    w_state_nxt = HELD;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = CNT_ZERO;
            end
        endcase
    end

    // Synchronizer, FSM state, counter and rise pulse registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync  <= 2'b00;
            r_state <= IDLE;
            r_cnt   <= CNT_ZERO;
            r_rise  <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], i_btn};
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_rise  <= w_rise_nxt;
        end
    end

endmodule

// File: rtl/sr_pulse_conditioner.sv
// Debounces set/reset buttons into one-cycle S/R pulses for a downstream SR
// latch; reset wins on simultaneous qualification and raises conflict.
module sr_pulse_conditioner
    import sr_cond_pkg::*;
#(
    parameter int DB_CYCLES = DEF_DB_CYCLES,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_set,
    input  logic btn_reset,
    output logic S,
    output logic R,
    output logic conflict,
    output logic q_model
);

    logic w_rise_set;
    logic w_rise_reset;
    logic r_s;
    logic r_r;
    logic r_conflict;
    logic r_q;

    debounce_channel #(
        .DB_CYCLES (DB_CYCLES),
        .CNT_W     (CNT_W)
    ) u_ch_set (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_btn  (btn_set),
        .o_rise (w_rise_set)
    );

    debounce_channel #(
        .DB_CYCLES (DB_CYCLES),
        .CNT_W     (CNT_W)
    ) u_ch_reset (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_btn  (btn_reset),
        .o_rise (w_rise_reset)
    );

    // Arbitration and output registers; q_model tracks the latch on the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s        <= 1'b0;
            r_r        <= 1'b0;
            r_conflict <= 1'b0;
            r_q        <= 1'b0;
        end else begin
            r_s        <= w_rise_set & ~w_rise_reset;
            r_r        <= w_rise_reset;
            r_conflict <= w_rise_set & w_rise_reset;
            if (w_rise_reset) begin
                r_q <= 1'b0;
            end else if (w_rise_set) begin
                r_q <= 1'b1;
            end else begin
                r_q <= r_q;
            end
        end
    end

    assign S        = r_s;
    assign R        = r_r;
    assign conflict = r_conflict;
    assign q_model  = r_q;

endmodule

// File: tb/tb_sr_pulse_conditioner.sv
// Directed bench for sr_pulse_conditioner (DB_CYCLES=8): press timing, bounce
// rejection, conflict arbitration, mid-press reset and a random bounce soak.
module tb_sr_pulse_conditioner;

    logic clk = 1'b0;
    logic rst_n;
    logic btn_set;
    logic btn_reset;
    logic S;
    logic R;
    logic conflict;
    logic q_model;

    int vectors    = 0;
    int miscompares = 0;

    sr_pulse_conditioner #(
        .DB_CYCLES (8),
        .CNT_W     (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_set   (btn_set),
        .btn_reset (btn_reset),
        .S         (S),
        .R         (R),
        .conflict  (conflict),
        .q_model   (q_model)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic es, input logic er,
                             input logic ec, input logic eq);
        chk({tag, "_S"}, S, es);
        chk({tag, "_R"}, R, er);
        chk({tag, "_conflict"}, conflict, ec);
        chk({tag, "_q"}, q_model, eq);
    endtask

    initial begin
        logic prev_s;
        logic prev_r;

        // Reset state
        rst_n     = 1'b0;
        btn_set   = 1'b0;
        btn_reset = 1'b0;
        step();
        step();
        check_all("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            check_all($sformatf("post_rst_k%0d", k), 1'b0, 1'b0, 1'b0, 1'b0);
        end

        // Set held 20 cycles: S only after edge 11
        for (int k = 0; k < 40; k++) begin
            btn_set = (k < 20);
            step();
            check_all($sformatf("set_hold_k%0d", k), (k == 11), 1'b0, 1'b0, (k >= 11));
        end

        // Bounce 3 high / 2 low / 3 high: rejected
        for (int k = 0; k < 25; k++) begin
            btn_set = (k < 3) || (k >= 5 && k < 8);
            step();
            check_all($sformatf("bounce_k%0d", k), 1'b0, 1'b0, 1'b0, 1'b1);
        end

        // Reset pulse at edge 6 of a 30-cycle set press
        for (int k = 0; k < 50; k++) begin
            btn_set = (k < 30);
            rst_n   = (k != 6);
            step();
            check_all($sformatf("midrst_k%0d", k), (k == 18), 1'b0, 1'b0,
                      (k < 6) || (k >= 18));
        end
        rst_n = 1'b1;

        // Simultaneous press: reset wins, conflict flagged
        for (int k = 0; k < 40; k++) begin
            btn_set   = (k < 20);
            btn_reset = (k < 20);
            step();
            check_all($sformatf("both_k%0d", k), 1'b0, (k == 11), (k == 11), (k < 11));
        end

        // Set press then reset press, 15 high / 15 low each
        for (int k = 0; k < 70; k++) begin
            btn_set   = (k < 15);
            btn_reset = (k >= 30) && (k < 45);
            step();
            check_all($sformatf("set_then_rst_k%0d", k), (k == 11), (k == 41), 1'b0,
                      (k >= 11) && (k < 41));
        end

        // Random bounce soak
        prev_s = S;
        prev_r = R;
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 15) == 0) btn_set = ~btn_set;
            if ($urandom_range(0, 15) == 0) btn_reset = ~btn_reset;
            step();
            chk("rand_s_and_r", S & R, 1'b0);
            chk("rand_s_width", S & prev_s, 1'b0);
            chk("rand_r_width", R & prev_r, 1'b0);
            chk("rand_conflict_without_r", conflict & ~R, 1'b0);
            if (S) chk("rand_q_after_s", q_model, 1'b1);
            if (R) chk("rand_q_after_r", q_model, 1'b0);
            prev_s = S;
            prev_r = R;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sr_pulse_conditioner.md
SR_PULSE_CONDITIONER -- requirements
Module: sr_pulse_conditioner

Interface
REQ-001 SHALL have parameter DB_CYCLES, default 8: debounce stability count in clock cycles; legal range 2..(2**CNT_W - 1).
REQ-002 SHALL have parameter CNT_W, default 4: debounce counter width.
REQ-003 SHALL have one clock, clk; reset is synchronous and active-low, rst_n.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  input  1  synchronous active-low reset.
REQ-006 btn_set  input  1  raw asynchronous, bouncing set button.
REQ-007 btn_reset  input  1  raw asynchronous, bouncing reset button.
REQ-008 S  output  1  registered one-cycle set pulse to the downstream SR latch S input.
REQ-009 R  output  1  registered one-cycle reset pulse to the downstream SR latch R input.
REQ-010 conflict  output  1  registered one-cycle flag: set and reset qualified in the same cycle.
REQ-011 q_model  output  1  registered expected latch state: 1 after S pulse, 0 after R pulse.

Function
REQ-012 Each raw input SHALL pass through a 2-flop synchronizer before any other use.
REQ-013 Each channel SHALL run a 4-state FSM: IDLE (debounced 0), CHK_HI, HELD (debounced 1), CHK_LO.
REQ-014 IDLE: sync=1 -> CHK_HI, cnt<=0; else stay.
REQ-015 CHK_HI: sync=0 -> IDLE; cnt==DB_CYCLES-1 -> HELD, assert rise for one cycle; else cnt++.
REQ-016 HELD: sync=0 -> CHK_LO, cnt<=0; else stay.
REQ-017 CHK_LO: sync=1 -> HELD; cnt==DB_CYCLES-1 -> IDLE; else cnt++.
REQ-018 Release SHALL produce no output pulse.
REQ-019 Latency: raw held high from the edge first sampling it; S/R high for exactly the cycle after the (DB_CYCLES+3)th rising edge.
REQ-020 A raw pulse or bounce shorter than DB_CYCLES+1 cycles SHALL produce no output pulse.
REQ-021 Holding a button indefinitely SHALL produce exactly one pulse.
REQ-022 S and R SHALL never be 1 in the same cycle.
REQ-023 Both rises in the same cycle: R=1, S=0, conflict=1 for that cycle; reset wins.
REQ-024 q_model SHALL update on the same edge S or R asserts; unchanged otherwise.
REQ-025 Counter SHALL never wrap; it saturates at DB_CYCLES-1 by construction of the transitions.

Reset
REQ-026 On rst_n=0 at a rising edge: synchronizers 0, FSMs IDLE, counters 0, S=0, R=0, conflict=0, q_model=0.
REQ-027 Reset mid-count SHALL abort without pulse; a button still held after release SHALL be re-debounced from IDLE and pulse once.
REQ-028 Outputs SHALL remain 0 for at least DB_CYCLES+2 cycles after rst_n rises.

Structure
REQ-029 Package sr_cond_pkg SHALL hold the FSM state enum (IDLE, CHK_HI, HELD, CHK_LO) and the default DB_CYCLES/CNT_W constants.
REQ-030 Sub-module debounce_channel (synchronizer, FSM, counter, rise output) SHALL be instantiated twice; the top holds arbitration and the output registers.

Verification
REQ-031 DB_CYCLES=8, btn_set high from edge 0 for 20 cycles -> S=1 only in the cycle after edge 11, q_model=1 thereafter, R=0 throughout.
REQ-032 btn_set bursts high 3 cycles, low 2, high 3 -> S, R, conflict stay 0.
REQ-033 btn_set and btn_reset rise at the same edge, both held 20 cycles -> single cycle R=1, conflict=1, S=0; q_model=0.
REQ-034 Set press then reset press, each 15 cycles high and 15 low -> one S pulse then one R pulse; q_model 0->1->0.
REQ-035 rst_n low for 1 cycle at cycle 6 of a set press held 30 cycles -> no pulse before reset; exactly one S pulse DB_CYCLES+3 edges after rst_n release.
REQ-036 Any random bouncing stimulus, 10k cycles -> assertion: never S&R; every pulse exactly one cycle wide.
